mem_arbiter: RTL

- Shares the single-port program/data memory between two requesters.
  - Port 0: the CPU.
  - Port 1: a secondary master, e.g. a switch-driven loader or debug reader.
- Sits between the requesters and the memory block, on the divided system clock.
- Sequences every access through a registered issue stage and returns read data with a fixed latency.
- Fixed priority by default; round-robin when the optional feature is enabled.

---
 rtl/mem_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port memory: registered issue stage, fixed 3-cycle read latency.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise port 0 wins every tie.
module mem_arbiter #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0,
   input  logic                  we0,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [DATA_WIDTH-1:0] wdata0,
   output logic                  gnt0,
   output logic                  rvalid0,
   output logic [DATA_WIDTH-1:0] rdata0,
   input  logic                  req1,
   input  logic                  we1,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] wdata1,
   output logic                  gnt1,
   output logic                  rvalid1,
   output logic [DATA_WIDTH-1:0] rdata1,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_data,
   input  logic [DATA_WIDTH-1:0] mem_out
);

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE0 = 2'd1, ISSUE1 = 2'd2} state_t;

   state_t                state_q, state_d;
   logic                  gnt0_q, gnt1_q;
   logic                  mem_we_q;
   logic [ADDR_WIDTH-1:0] mem_addr_q;
   logic [DATA_WIDTH-1:0] mem_data_q;
   logic                  rd_pend_p1_q, rd_own_p1_q;
   logic                  rvalid0_q, rvalid1_q;
   logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;
   logic                  elig0, elig1, pick1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic                  last1_q;
`endif

   // A port in its own grant cycle is not eligible, so a held request is not issued twice.
   always_comb begin
      elig0 = req0 & ~gnt0_q;
      elig1 = req1 & ~gnt1_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      pick1 = elig1 & (~elig0 | ~last1_q);
`else
      pick1 = elig1 & ~elig0;
`endif
      if (pick1) begin
         state_d = ISSUE1;
      end else if (elig0) begin
         state_d = ISSUE0;
      end else begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         gnt0_q       <= 1'b0;
         gnt1_q       <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_data_q   <= '0;
         rd_pend_p1_q <= 1'b0;
         rd_own_p1_q  <= 1'b0;
         rvalid0_q    <= 1'b0;
         rvalid1_q    <= 1'b0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         last1_q      <= 1'b1;
`endif
      end else begin
         // Issue stage: latch the winner's access; address/data hold while idle.
         state_q <= state_d;
         gnt0_q  <= (state_d == ISSUE0);
         gnt1_q  <= (state_d == ISSUE1);
         case (state_d)
            ISSUE0: begin
               mem_we_q   <= we0;
               mem_addr_q <= addr0;
               mem_data_q <= wdata0;
            end
            ISSUE1: begin
               mem_we_q   <= we1;
               mem_addr_q <= addr1;
               mem_data_q <= wdata1;
            end
            default: mem_we_q <= 1'b0;
         endcase
`ifdef MEM_ARB_ROUND_ROBIN_EN
         if (state_d != IDLE) begin
            last1_q <= (state_d == ISSUE1);
         end
`endif
         // Stage p1: memory is reading; stage p2: capture mem_out into the owner's port.
         rd_pend_p1_q <= (state_q != IDLE) & ~mem_we_q;
         rd_own_p1_q  <= (state_q == ISSUE1);
         rvalid0_q    <= rd_pend_p1_q & ~rd_own_p1_q;
         rvalid1_q    <= rd_pend_p1_q & rd_own_p1_q;
         if (rd_pend_p1_q & ~rd_own_p1_q) begin
            rdata0_q <= mem_out;
         end
         if (rd_pend_p1_q & rd_own_p1_q) begin
            rdata1_q <= mem_out;
         end
      end
   end

   assign gnt0     = gnt0_q;
   assign gnt1     = gnt1_q;
   assign mem_we   = mem_we_q;
   assign mem_addr = mem_addr_q;
   assign mem_data = mem_data_q;
   assign rvalid0  = rvalid0_q;
   assign rvalid1  = rvalid1_q;
   assign rdata0   = rdata0_q;
   assign rdata1   = rdata1_q;

endmodule
